agc_ctrl_param: RTL and testbench

AGC_CTRL_PARAM -- requirements
Module: agc_ctrl_param

---
 rtl/agc_ctrl_param.sv | 257 +++++++++++++++++++++++++
 tb/tb_agc_ctrl_param.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/agc_ctrl_param.sv
// -----------------------------------------------------------------------------
// agc_ctrl_param
// Automatic gain control for an ADC front end. Collects peak and valley over a
// window of accepted samples, compares them against per-gain-index limits and
// steps a relay gain index up or down. Samples right after a gain change are
// discarded while the analog path settles. An over-voltage sample forces an
// immediate downshift. A sample-valid watchdog drops the gain to the lowest
// step when the ADC goes silent. A manual mode lets software pin the index.
// Override priority: reset, watchdog, manual, automatic FSM.
// All threshold comparisons are unsigned at DATA_W width.
// Supported range: N_GAIN 2..16, WIN_LOG2 >= 1.
// -----------------------------------------------------------------------------
module agc_ctrl_param #(
   parameter int DATA_W     = 12,
   parameter int N_GAIN     = 4,
   parameter int WIN_LOG2   = 9,
   parameter int SETTLE_SMP = 5,
   parameter int WDT_CYC    = 24'hFFFFFF,
   localparam int GW        = $clog2(N_GAIN)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sample_valid,
   input  logic [DATA_W-1:0]        sample_data,
   input  logic [N_GAIN*DATA_W-1:0] lower_tbl,
   input  logic [N_GAIN*DATA_W-1:0] upper_tbl,
   input  logic [DATA_W-1:0]        ovp_thr,
   input  logic                     manual_en,
   input  logic [GW-1:0]            manual_idx,
   output logic [GW-1:0]            gain_idx,
   output logic                     gain_change,
   output logic                     stable,
   output logic                     clip,
   output logic                     wdt_timeout
);

   // Counter widths; keep at least one bit even for degenerate settings
   localparam int ST_W  = (SETTLE_SMP > 0) ? $clog2(SETTLE_SMP + 1) : 1;
   localparam int WDT_W = (WDT_CYC > 0) ? $clog2(WDT_CYC + 1) : 1;

   localparam logic [GW-1:0]       MAX_IDX    = GW'(N_GAIN - 1);
   localparam logic [GW-1:0]       IDX_ONE    = GW'(1);
   localparam logic [WIN_LOG2-1:0] CNT_ONE    = WIN_LOG2'(1);
   localparam logic [WIN_LOG2-1:0] CNT_LAST   = {WIN_LOG2{1'b1}};
   localparam logic [ST_W-1:0]     SETTLE_LD  = ST_W'(SETTLE_SMP);
   localparam logic [ST_W-1:0]     SETTLE_ONE = ST_W'(1);
   localparam logic [WDT_W-1:0]    WDT_MAX    = WDT_W'(WDT_CYC);
   localparam logic [WDT_W-1:0]    WDT_ONE    = WDT_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SAMPLE = 3'd1,
      ST_EVAL   = 3'd2,
      ST_ADJUST = 3'd3,
      ST_SETTLE = 3'd4
   } state_t;

   // Registered state
   state_t               state_r;
   logic [DATA_W-1:0]    peak_r;
   logic [DATA_W-1:0]    valley_r;
   logic [WIN_LOG2-1:0]  cnt_r;
   logic [ST_W-1:0]      settle_r;
   logic [GW-1:0]        target_r;
   logic [GW-1:0]        gain_idx_r;
   logic                 gain_change_r;
   logic                 stable_r;
   logic                 clip_r;
   logic [WDT_W-1:0]     wdt_cnt_r;
   logic                 wdt_timeout_r;

   // Next-state values
   state_t               state_nxt_s;
   logic [DATA_W-1:0]    peak_nxt_s;
   logic [DATA_W-1:0]    valley_nxt_s;
   logic [WIN_LOG2-1:0]  cnt_nxt_s;
   logic [ST_W-1:0]      settle_nxt_s;
   logic [GW-1:0]        target_nxt_s;
   logic [GW-1:0]        gain_nxt_s;
   logic                 stable_nxt_s;
   logic                 clip_nxt_s;
   logic [WDT_W-1:0]     wdt_nxt_s;

   // Helpers
   logic [DATA_W-1:0]    upper_s;
   logic [DATA_W-1:0]    lower_s;
   logic [GW-1:0]        man_idx_s;
   logic                 ovp_s;
   logic                 hi_viol_s;
   logic                 lo_viol_s;

   // Limits for the current gain step
   assign upper_s   = upper_tbl[int'(gain_idx_r) * DATA_W +: DATA_W];
   assign lower_s   = lower_tbl[int'(gain_idx_r) * DATA_W +: DATA_W];
   assign man_idx_s = (manual_idx > MAX_IDX) ? MAX_IDX : manual_idx;
   assign ovp_s     = (sample_data >= ovp_thr);
   assign hi_viol_s = (peak_r > upper_s);
   assign lo_viol_s = (valley_r < lower_s);

   // Watchdog: clear on any valid sample, otherwise count up and saturate
   always_comb begin
      wdt_nxt_s = wdt_cnt_r;
      if (sample_valid) begin
         wdt_nxt_s = '0;
      end else if (wdt_cnt_r == WDT_MAX) begin
         wdt_nxt_s = wdt_cnt_r;
      end else begin
         wdt_nxt_s = wdt_cnt_r + WDT_ONE;
      end
   end

   // Next-state logic: watchdog and manual overrides first, then the AGC FSM
   always_comb begin
      state_nxt_s  = state_r;
      peak_nxt_s   = peak_r;
      valley_nxt_s = valley_r;
      cnt_nxt_s    = cnt_r;
      settle_nxt_s = settle_r;
      target_nxt_s = target_r;
      gain_nxt_s   = gain_idx_r;
      stable_nxt_s = stable_r;
      clip_nxt_s   = clip_r;

      if (wdt_timeout_r) begin
         // Silent ADC: fall back to the lowest gain and restart cleanly
         state_nxt_s  = ST_IDLE;
         gain_nxt_s   = '0;
         stable_nxt_s = 1'b0;
      end else if (manual_en) begin
         // Software owns the gain; auto mode restarts from IDLE on release
         state_nxt_s  = ST_IDLE;
         stable_nxt_s = 1'b0;
         gain_nxt_s   = man_idx_s;
      end else begin
         case (state_r)
            ST_IDLE: begin
               peak_nxt_s   = '0;
               valley_nxt_s = {DATA_W{1'b1}};
               cnt_nxt_s    = '0;
               state_nxt_s  = ST_SAMPLE;
            end

            ST_SAMPLE: begin
               if (!sample_valid) begin
                  state_nxt_s = ST_SAMPLE;
               end else if (ovp_s) begin
                  // Over-voltage: downshift at once, sample not accumulated
                  if (gain_idx_r == '0) begin
                     clip_nxt_s   = 1'b1;
                     stable_nxt_s = 1'b0;
                     state_nxt_s  = ST_IDLE;
                  end else begin
                     target_nxt_s = gain_idx_r - IDX_ONE;
                     state_nxt_s  = ST_ADJUST;
                  end
               end else begin
                  peak_nxt_s   = (sample_data > peak_r)   ? sample_data : peak_r;
                  valley_nxt_s = (sample_data < valley_r) ? sample_data : valley_r;
                  cnt_nxt_s    = cnt_r + CNT_ONE;
                  if (cnt_r == CNT_LAST) begin
                     state_nxt_s = ST_EVAL;
                  end else begin
                     state_nxt_s = ST_SAMPLE;
                  end
               end
            end

            ST_EVAL: begin
               // High violation is checked first so it wins over a low one
               if (hi_viol_s) begin
                  if (gain_idx_r == '0) begin
                     clip_nxt_s   = 1'b1;
                     stable_nxt_s = 1'b0;
                     state_nxt_s  = ST_IDLE;
                  end else begin
                     target_nxt_s = gain_idx_r - IDX_ONE;
                     state_nxt_s  = ST_ADJUST;
                  end
               end else if (lo_viol_s) begin
                  if (gain_idx_r == MAX_IDX) begin
                     stable_nxt_s = 1'b0;
                     state_nxt_s  = ST_IDLE;
                  end else begin
                     target_nxt_s = gain_idx_r + IDX_ONE;
                     state_nxt_s  = ST_ADJUST;
                  end
               end else begin
                  stable_nxt_s = 1'b1;
                  clip_nxt_s   = 1'b0;
                  state_nxt_s  = ST_IDLE;
               end
            end

            ST_ADJUST: begin
               gain_nxt_s   = target_r;
               stable_nxt_s = 1'b0;
               settle_nxt_s = SETTLE_LD;
               state_nxt_s  = ST_SETTLE;
            end

            ST_SETTLE: begin
               // Discard SETTLE_SMP+1 samples, over-voltage included
               if (!sample_valid) begin
                  state_nxt_s = ST_SETTLE;
               end else if (settle_r == '0) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  settle_nxt_s = settle_r - SETTLE_ONE;
                  state_nxt_s  = ST_SETTLE;
               end
            end

            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // State and output registers; gain_change marks the cycle gain_idx moves
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         peak_r        <= '0;
         valley_r      <= {DATA_W{1'b1}};
         cnt_r         <= '0;
         settle_r      <= '0;
         target_r      <= '0;
         gain_idx_r    <= '0;
         gain_change_r <= 1'b0;
         stable_r      <= 1'b0;
         clip_r        <= 1'b0;
         wdt_cnt_r     <= '0;
         wdt_timeout_r <= 1'b0;
      end else begin
         state_r       <= state_nxt_s;
         peak_r        <= peak_nxt_s;
         valley_r      <= valley_nxt_s;
         cnt_r         <= cnt_nxt_s;
         settle_r      <= settle_nxt_s;
         target_r      <= target_nxt_s;
         gain_idx_r    <= gain_nxt_s;
         gain_change_r <= (gain_nxt_s != gain_idx_r);
         stable_r      <= stable_nxt_s;
         clip_r        <= clip_nxt_s;
         wdt_cnt_r     <= wdt_nxt_s;
         wdt_timeout_r <= (wdt_nxt_s == WDT_MAX);
      end
   end

   assign gain_idx    = gain_idx_r;
   assign gain_change = gain_change_r;
   assign stable      = stable_r;
   assign clip        = clip_r;
   assign wdt_timeout = wdt_timeout_r;

endmodule

// File: tb/tb_agc_ctrl_param.sv
// -----------------------------------------------------------------------------
// tb_agc_ctrl_param
// Window scenarios come from a table; each scenario's expected outcome is
// queued when its stimulus starts and popped when the window has resolved.
// Over-voltage, watchdog and mid-window reset are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_agc_ctrl_param;

   localparam int DW = 12;
   localparam int NG = 4;

   logic             clk;
   logic             rst_n;
   logic             sample_valid;
   logic [DW-1:0]    sample_data;
   logic [NG*DW-1:0] lower_tbl;
   logic [NG*DW-1:0] upper_tbl;
   logic [DW-1:0]    ovp_thr;
   logic             manual_en;
   logic [1:0]       manual_idx;
   logic [1:0]       gain_idx;
   logic             gain_change;
   logic             stable;
   logic             clip;
   logic             wdt_timeout;

   int n_pass;
   int n_total;
   int chg_cnt;

   typedef struct {
      int use_man;
      int man_idx;
      int a;
      int b;
      int e_idx;
      int e_stable;
      int e_clip;
      int e_chg;
   } vec_t;

   vec_t tbl[11];
   vec_t exp_q[$];

   agc_ctrl_param #(
      .DATA_W     (12),
      .N_GAIN     (4),
      .WIN_LOG2   (4),
      .SETTLE_SMP (2),
      .WDT_CYC    (100)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .lower_tbl    (lower_tbl),
      .upper_tbl    (upper_tbl),
      .ovp_thr      (ovp_thr),
      .manual_en    (manual_en),
      .manual_idx   (manual_idx),
      .gain_idx     (gain_idx),
      .gain_change  (gain_change),
      .stable       (stable),
      .clip         (clip),
      .wdt_timeout  (wdt_timeout)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count gain_change pulses
   always @(posedge clk) begin
      if (gain_change) chg_cnt <= chg_cnt + 1;
   end

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "time limit");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // One valid sample followed by three idle cycles
   task automatic send(input int v);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = DW'(v);
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic run_window(input int a, input int b);
      for (int i = 0; i < 16; i++) send(((i % 2) == 0) ? a : b);
   endtask

   task automatic set_manual(input int idx);
      @(negedge clk);
      manual_en  = 1'b1;
      manual_idx = 2'(idx);
      repeat (3) @(negedge clk);
      manual_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      vec_t e;
      int   c0;

      n_pass = 0; n_total = 0; chg_cnt = 0;
      rst_n = 1'b1; sample_valid = 1'b0; sample_data = '0;
      manual_en = 1'b0; manual_idx = '0;
      lower_tbl = {NG{12'd1791}};
      upper_tbl = {NG{12'd3685}};
      ovp_thr   = 12'd3941;

      //          man idx a     b     e_idx st clip chg
      tbl[0]  = '{1, 0, 2000, 3000, 0, 1, 0, 0};  // in range at idx 0
      tbl[1]  = '{0, 0, 500,  500,  1, 0, 0, 1};  // low -> 1
      tbl[2]  = '{0, 0, 500,  500,  2, 0, 0, 1};  // low -> 2
      tbl[3]  = '{0, 0, 500,  500,  3, 0, 0, 1};  // low -> 3
      tbl[4]  = '{0, 0, 500,  500,  3, 0, 0, 0};  // saturated high end
      tbl[5]  = '{1, 2, 3800, 1000, 1, 0, 0, 1};  // both violated, downshift
      tbl[6]  = '{1, 0, 3800, 2000, 0, 0, 1, 0};  // high at idx 0 -> clip
      tbl[7]  = '{0, 0, 2000, 3000, 0, 1, 0, 0};  // in range clears clip
      tbl[8]  = '{1, 3, 3685, 1791, 3, 1, 0, 0};  // exact limits are in range
      tbl[9]  = '{1, 1, 3686, 2000, 0, 0, 0, 1};  // one above upper
      tbl[10] = '{1, 1, 2000, 1790, 2, 0, 0, 1};  // one below lower

      // Reset
      #3 rst_n = 1'b0;
      #20;
      chk("rst_gain_idx", int'(gain_idx), 0);
      chk("rst_gain_change", int'(gain_change), 0);
      chk("rst_stable", int'(stable), 0);
      chk("rst_clip", int'(clip), 0);
      chk("rst_wdt", int'(wdt_timeout), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven windows
      for (int k = 0; k < 11; k++) begin
         if (tbl[k].use_man != 0) set_manual(tbl[k].man_idx);
         c0 = chg_cnt;
         exp_q.push_back(tbl[k]);
         run_window(tbl[k].a, tbl[k].b);
         if (tbl[k].e_chg != 0) repeat (3) send(4000);  // settle, ignored
         if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("win%0d_gain_idx", k), int'(gain_idx), e.e_idx);
            chk($sformatf("win%0d_stable", k), int'(stable), e.e_stable);
            chk($sformatf("win%0d_clip", k), int'(clip), e.e_clip);
            chk($sformatf("win%0d_changes", k), chg_cnt - c0, e.e_chg);
         end
      end

      // Over-voltage at idx 2 on sample #5: ADJUST next cycle, then idx 1
      set_manual(2);
      c0 = chg_cnt;
      repeat (4) send(2000);
      @(negedge clk);
      sample_valid = 1'b1; sample_data = 12'd4000;
      @(negedge clk);
      sample_valid = 1'b0;
      chk("ovp2_in_adjust_idx", int'(gain_idx), 2);
      @(negedge clk);
      chk("ovp2_gain_idx", int'(gain_idx), 1);
      chk("ovp2_gain_change", int'(gain_change), 1);
      repeat (3) send(4000);
      chk("ovp2_changes", chg_cnt - c0, 1);
      chk("ovp2_clip", int'(clip), 0);

      // Over-voltage at idx 0: clip, gain stays
      set_manual(0);
      c0 = chg_cnt;
      chk("ovp0_clip_before", int'(clip), 0);
      repeat (4) send(2000);
      send(4000);
      chk("ovp0_clip", int'(clip), 1);
      chk("ovp0_gain_idx", int'(gain_idx), 0);
      chk("ovp0_changes", chg_cnt - c0, 0);

      // Watchdog at idx 3
      set_manual(3);
      @(negedge clk);
      sample_valid = 1'b1; sample_data = 12'd2000;
      @(negedge clk);
      sample_valid = 1'b0;
      c0 = chg_cnt;
      repeat (95) @(negedge clk);
      chk("wdt_early", int'(wdt_timeout), 0);
      chk("wdt_early_gain", int'(gain_idx), 3);
      repeat (10) @(negedge clk);
      chk("wdt_timeout", int'(wdt_timeout), 1);
      chk("wdt_gain_idx", int'(gain_idx), 0);
      chk("wdt_stable", int'(stable), 0);
      chk("wdt_changes", chg_cnt - c0, 1);
      @(negedge clk);
      sample_valid = 1'b1; sample_data = 12'd2000;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      chk("wdt_cleared", int'(wdt_timeout), 0);
      repeat (3) @(negedge clk);

      // Manual idx 3, then reset mid-window
      @(negedge clk);
      manual_en = 1'b1; manual_idx = 2'd3;
      repeat (3) @(negedge clk);
      chk("man_gain_idx", int'(gain_idx), 3);
      manual_en = 1'b0;
      repeat (3) @(negedge clk);
      repeat (5) send(2000);
      c0 = chg_cnt;
      rst_n = 1'b0;
      #1;
      chk("mrst_gain_idx", int'(gain_idx), 0);
      chk("mrst_gain_change", int'(gain_change), 0);
      chk("mrst_stable", int'(stable), 0);
      chk("mrst_clip", int'(clip), 0);
      chk("mrst_wdt", int'(wdt_timeout), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mrst_no_pulse", chg_cnt - c0, 0);
      // Fresh window after reset: 11 samples must not complete it
      for (int i = 0; i < 11; i++) send(((i % 2) == 0) ? 2000 : 3000);
      chk("mrst_partial_stable", int'(stable), 0);
      for (int i = 11; i < 16; i++) send(((i % 2) == 0) ? 2000 : 3000);
      chk("mrst_full_stable", int'(stable), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
